// File: rtl/tdc_ser_tx.sv
// tdc_ser_tx: serial transmitter for the TDC link.
// Takes pre-encoded 8b10b words over valid/ready and shifts them out MSB-first,
// one bit per FCLK. Free word slots are filled with K28.1 commas that follow
// the running disparity.
// Optional feature: define TDC_SER_TX_TRAINING_EN to force TRAIN_WORDS commas
// after reset and after every train_req pulse.
module tdc_ser_tx #(
    parameter int DSIZE       = 10,
    parameter int TRAIN_WORDS = 16
) (
    input  logic             FCLK,
    input  logic             reset,
    input  logic [DSIZE-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             train_req,
    output logic             dout,
    output logic             word_strobe,
    output logic             rd,
    output logic             disp_err,
    output logic [15:0]      sent_cnt
);

    localparam int CW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam int PW = $clog2(DSIZE + 1);
    // K28.1 for each running disparity
    localparam logic [DSIZE-1:0] COMMA_NEG = DSIZE'(10'b0011111001);
    localparam logic [DSIZE-1:0] COMMA_POS = DSIZE'(10'b1100000110);

    logic [DSIZE-1:0] shift_reg;
    logic [DSIZE-1:0] hold_reg;
    logic [DSIZE-1:0] load_word;
    logic [CW-1:0]    bit_cnt;
    logic [PW-1:0]    ones;
    logic             hold_full;
    logic             training;
    logic             load;
    logic             take_data;
    logic             accept;

    assign load       = (bit_cnt == CW'(DSIZE - 1));
    assign take_data  = hold_full && !training;
    assign data_ready = !hold_full && !training;
    assign accept     = data_valid && data_ready;
    assign dout       = shift_reg[DSIZE-1];

`ifdef TDC_SER_TX_TRAINING_EN
    logic [7:0] train_cnt;

    assign training = (train_cnt != 8'd0);

    // Training counter: reloaded by reset or train_req, one comma consumed per load
    always_ff @(posedge FCLK) begin
        if (reset || train_req)
            train_cnt <= 8'(TRAIN_WORDS);
        else if (load && training)
            train_cnt <= train_cnt - 8'd1;
    end
`else
    logic [1:0] unused_train;

    assign training     = 1'b0;
    assign unused_train = {train_req, TRAIN_WORDS[0]};
`endif

    // Next word to load and its ones count for the disparity update
    always_comb begin
        load_word = take_data ? hold_reg : (rd ? COMMA_POS : COMMA_NEG);
        ones      = '0;
        for (int i = 0; i < DSIZE; i++)
            ones = ones + PW'(load_word[i]);
    end

    // Shifter, bit counter, holding register, disparity and statistics
    always_ff @(posedge FCLK) begin
        if (reset) begin
            shift_reg   <= '0;
            hold_reg    <= '0;
            bit_cnt     <= CW'(DSIZE - 1);
            hold_full   <= 1'b0;
            word_strobe <= 1'b0;
            rd          <= 1'b0;
            disp_err    <= 1'b0;
            sent_cnt    <= 16'd0;
        end else begin
            if (load) begin
                shift_reg   <= load_word;
                bit_cnt     <= '0;
                word_strobe <= 1'b1;
                if (ones == PW'(DSIZE / 2 + 1))
                    rd <= 1'b1;
                else if (ones == PW'(DSIZE / 2 - 1))
                    rd <= 1'b0;
                else if (ones != PW'(DSIZE / 2))
                    disp_err <= 1'b1;
                if (take_data) begin
                    hold_full <= 1'b0;
                    sent_cnt  <= sent_cnt + 16'd1;
                end
            end else begin
                shift_reg   <= {shift_reg[DSIZE-2:0], 1'b0};
                bit_cnt     <= bit_cnt + CW'(1);
                word_strobe <= 1'b0;
            end
            // ready is low while hold_full, so this never collides with a data load
            if (accept) begin
                hold_reg  <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_ser_tx.sv
// tb_tdc_ser_tx: directed bench for tdc_ser_tx with hand-computed words.
// Honours TDC_SER_TX_TRAINING_EN (TRAIN_WORDS = 4) when the macro is defined.
module tb_tdc_ser_tx;

`ifdef TDC_SER_TX_TRAINING_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    localparam logic [9:0] C0 = 10'b0011111001;  // comma at RD-
    localparam logic [9:0] C1 = 10'b1100000110;  // comma at RD+
    localparam logic [9:0] WA = 10'b1010101010;  // 5 ones
    localparam logic [9:0] WB = 10'b0111010101;  // 6 ones
    localparam logic [9:0] WD = 10'b1000110001;  // 4 ones
    localparam logic [9:0] WE = 10'h155;         // 5 ones
    localparam logic [9:0] WF = 10'h2AA;         // 5 ones
    localparam logic [9:0] WG = 10'b1111111000;  // 7 ones
    localparam logic [9:0] WH = 10'b0000011111;  // 5 ones, dropped by reset

    logic        FCLK = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        train_req = 1'b0;
    logic        dout;
    logic        word_strobe;
    logic        rd;
    logic        disp_err;
    logic [15:0] sent_cnt;

    int ntests = 0;
    int nfail  = 0;

    tdc_ser_tx #(.DSIZE(10), .TRAIN_WORDS(4)) dut (
        .FCLK        (FCLK),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .train_req   (train_req),
        .dout        (dout),
        .word_strobe (word_strobe),
        .rd          (rd),
        .disp_err    (disp_err),
        .sent_cnt    (sent_cnt)
    );

    always #5 FCLK = ~FCLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Collect one 10-bit slot from dout (sampled on negedges), optionally
    // offering a word at bit 2 and pulsing train_req at bit 4.
    task automatic word(input string tag, input logic [9:0] exp, input logic exp_rd,
                        input bit push = 1'b0, input logic [9:0] pd = '0,
                        input bit treq = 1'b0);
        logic [9:0] w;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge FCLK);
            w = {w[8:0], dout};
            if (i == 0) chk({tag, ".strb"}, 32'(word_strobe), 32'd1);
            if (i == 1) chk({tag, ".strb_lo"}, 32'(word_strobe), 32'd0);
            if (push && i == 2) begin
                chk({tag, ".rdy"}, 32'(data_ready), 32'd1);
                data_in    = pd;
                data_valid = 1'b1;
            end
            if (i == 3) begin
                if (push) chk({tag, ".rdy_lo"}, 32'(data_ready), 32'd0);
                data_valid = 1'b0;
            end
            if (treq && i == 4) train_req = 1'b1;
            if (i == 5) train_req = 1'b0;
        end
        chk(tag, 32'(w), 32'(exp));
        chk({tag, ".rd"}, 32'(rd), 32'(exp_rd));
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge FCLK);
        chk("rst.dout", 32'(dout), 32'd0);
        chk("rst.strb", 32'(word_strobe), 32'd0);
        chk("rst.rd", 32'(rd), 32'd0);
        chk("rst.derr", 32'(disp_err), 32'd0);
        chk("rst.cnt", 32'(sent_cnt), 32'd0);
        chk("rst.rdy", 32'(data_ready), 32'(!TR));
        reset = 1'b0;

        // idle: alternating commas, rd toggles
        word("idle0", C0, 1'b1);
        word("idle1", C1, 1'b0);
        word("idle2", C0, 1'b1);
        word("idle3", C1, 1'b0);
        chk("idle.cnt", 32'(sent_cnt), 32'd0);
        chk("idle.rdy", 32'(data_ready), 32'd1);

        // balanced word accepted at rd=0
        word("a.c0", C0, 1'b1);
        word("a.c1", C1, 1'b0, 1'b1, WA);
        word("a.w", WA, 1'b0);
        word("a.next", C0, 1'b1);
        chk("a.cnt", 32'(sent_cnt), 32'd1);

        // 6-ones word forces RD+, next comma is the RD+ form
        word("b.c1", C1, 1'b0, 1'b1, WB);
        word("b.w", WB, 1'b1);
        word("b.next", C1, 1'b0);

        // 6-ones then 4-ones back to back
        word("d.c0", C0, 1'b1, 1'b1, WB);
        word("d.wb", WB, 1'b1, 1'b1, WD);
        word("d.wd", WD, 1'b0);
        word("d.next", C0, 1'b1);
        chk("d.cnt", 32'(sent_cnt), 32'd4);

        // 0x155 / 0x2AA on consecutive slots
        word("e.c1", C1, 1'b0, 1'b1, WE);
        word("e.we", WE, 1'b0, 1'b1, WF);
        word("e.wf", WF, 1'b0);
        word("e.next", C0, 1'b1);
        chk("e.cnt", 32'(sent_cnt), 32'd6);

        // 7-ones word: sticky disp_err, rd unchanged
        word("g.c1", C1, 1'b0, 1'b1, WG);
        chk("g.derr_pre", 32'(disp_err), 32'd0);
        word("g.w", WG, 1'b0);
        chk("g.derr", 32'(disp_err), 32'd1);
        word("g.next", C0, 1'b1);
        chk("g.derr_hold", 32'(disp_err), 32'd1);
        chk("g.cnt", 32'(sent_cnt), 32'd7);

        // reset at bit 5 of a word with a held word pending
        for (int i = 0; i < 6; i++) begin
            @(negedge FCLK);
            if (i == 2) begin data_in = WH; data_valid = 1'b1; end
            if (i == 3) data_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge FCLK);
        chk("mrst.dout", 32'(dout), 32'd0);
        chk("mrst.strb", 32'(word_strobe), 32'd0);
        chk("mrst.rd", 32'(rd), 32'd0);
        chk("mrst.derr", 32'(disp_err), 32'd0);
        chk("mrst.cnt", 32'(sent_cnt), 32'd0);
        chk("mrst.rdy", 32'(data_ready), 32'(!TR));
        reset = 1'b0;
        word("mrst0", C0, 1'b1);
        chk("mrst.rdy1", 32'(data_ready), 32'(!TR));
        word("mrst1", C1, 1'b0);
        word("mrst2", C0, 1'b1);
        word("mrst3", C1, 1'b0);
        chk("mrst.rdy4", 32'(data_ready), 32'd1);
        chk("mrst.cnt2", 32'(sent_cnt), 32'd0);

`ifdef TDC_SER_TX_TRAINING_EN
        // train_req with a held word: four commas first, then the word
        word("t.c0", C0, 1'b1, 1'b1, WE, 1'b1);
        word("t.k0", C1, 1'b0);
        chk("t.rdy", 32'(data_ready), 32'd0);
        word("t.k1", C0, 1'b1);
        word("t.k2", C1, 1'b0);
        word("t.k3", C0, 1'b1);
        word("t.w", WE, 1'b1);
        word("t.next", C1, 1'b0);
        chk("t.cnt", 32'(sent_cnt), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
